// File: rtl/timer_display_ctrl_pkg.sv
// rtl/timer_display_ctrl_pkg.sv - shared types and constants for the kitchen-timer display controller
// Purpose : FSM state encoding, digit-code nibbles, BCD limits and the digit-code helper.
// Ports   : none (package).
package timer_display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    localparam logic [3:0] NIB_VISIBLE  = 4'h0;
    localparam logic [3:0] NIB_BLANK    = 4'hF;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Display digit: upper nibble selects visible/blanked, lower nibble is the BCD value.
    function automatic logic [7:0] digit_code(input logic blank, input logic [3:0] val);
        return {(blank ? NIB_BLANK : NIB_VISIBLE), val};
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// rtl/bcd_mmss_counter.sv - four-digit MM:SS BCD counter with edit and countdown operations
// Purpose : holds the time digits; clear, minutes +1 (99->00), seconds +1 (59->00, no carry),
//           decrement with borrow from seconds into minutes.
// Ports   : dclk_i, clr_n_i (sync active-low reset), clear_i, inc_min_i, inc_sec_i, dec_i (one-hot
//           commands, clear wins), mm_tens_o/mm_ones_o/ss_tens_o/ss_ones_o digits, zero_o (00:00),
//           one_o (00:01, i.e. the next decrement lands on 00:00).
module bcd_mmss_counter
    import timer_display_ctrl_pkg::*;
(
    input  logic       dclk_i,
    input  logic       clr_n_i,
    input  logic       clear_i,
    input  logic       inc_min_i,
    input  logic       inc_sec_i,
    input  logic       dec_i,
    output logic [3:0] mm_tens_o,
    output logic [3:0] mm_ones_o,
    output logic [3:0] ss_tens_o,
    output logic [3:0] ss_ones_o,
    output logic       zero_o,
    output logic       one_o
);

    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clear_i) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = 4'd0;
            so_d = 4'd0;
        end else if (inc_min_i) begin
            if (mo_q == DIGIT_MAX) begin
                mo_d = 4'd0;
                mt_d = (mt_q == DIGIT_MAX) ? 4'd0 : mt_q + 4'd1;
            end else begin
                mo_d = mo_q + 4'd1;
            end
        end else if (inc_sec_i) begin
            if (so_q == DIGIT_MAX) begin
                so_d = 4'd0;
                st_d = (st_q == SEC_TENS_MAX) ? 4'd0 : st_q + 4'd1;
            end else begin
                so_d = so_q + 4'd1;
            end
        end else if (dec_i) begin
            if (so_q == 4'd0) begin
                so_d = DIGIT_MAX;
                if (st_q == 4'd0) begin
                    // ss==00: seconds go to 59 and minutes borrow
                    st_d = SEC_TENS_MAX;
                    if (mo_q == 4'd0) begin
                        mo_d = DIGIT_MAX;
                        mt_d = (mt_q == 4'd0) ? DIGIT_MAX : mt_q - 4'd1;
                    end else begin
                        mo_d = mo_q - 4'd1;
                    end
                end else begin
                    st_d = st_q - 4'd1;
                end
            end else begin
                so_d = so_q - 4'd1;
            end
        end
    end

    always_ff @(posedge dclk_i) begin
        if (!clr_n_i) begin
            mt_q <= 4'd0;
            mo_q <= 4'd0;
            st_q <= 4'd0;
            so_q <= 4'd0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign mm_tens_o = mt_q;
    assign mm_ones_o = mo_q;
    assign ss_tens_o = st_q;
    assign ss_ones_o = so_q;
    assign zero_o    = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign one_o     = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

endmodule

// File: rtl/timer_display_ctrl.sv
// rtl/timer_display_ctrl.sv - kitchen-timer sequencer driving the MM:SS seven-segment digits
// Purpose : IDLE/RUN/PAUSE/ALARM FSM, 1 s tick and alarm blink prescalers, vsync rising-edge
//           detector and frame-gated shadow registers for bcd1..bcd4.
// Ports   : dclk (pixel clock), clr_n (sync active-low reset), vsync (frame boundary on rise),
//           btn_start/btn_stop/btn_min/btn_sec (one-cycle pulses), bcd1..bcd4 (MM:SS digit codes),
//           alarm (in ALARM), running (in RUN).
module timer_display_ctrl
    import timer_display_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 25_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       vsync,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [7:0] bcd1,
    output logic [7:0] bcd2,
    output logic [7:0] bcd3,
    output logic [7:0] bcd4,
    output logic       alarm,
    output logic       running
);

    localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               vsync_prev_q;
    logic [31:0]        bcd_q, bcd_d;
    logic               running_q, alarm_q;

    logic       tick;
    logic       cnt_clear, cnt_inc_min, cnt_inc_sec, cnt_dec;
    logic [3:0] mm_tens, mm_ones, ss_tens, ss_ones;
    logic       time_zero, time_one;
    logic       any_btn, blank, frame_edge;

    bcd_mmss_counter u_counter (
        .dclk_i    (dclk),
        .clr_n_i   (clr_n),
        .clear_i   (cnt_clear),
        .inc_min_i (cnt_inc_min),
        .inc_sec_i (cnt_inc_sec),
        .dec_i     (cnt_dec),
        .mm_tens_o (mm_tens),
        .mm_ones_o (mm_ones),
        .ss_tens_o (ss_tens),
        .ss_ones_o (ss_ones),
        .zero_o    (time_zero),
        .one_o     (time_one)
    );

    // Prescalers sit at zero outside their state, which gives the clear-on-entry behaviour.
    assign tick = (state_q == ST_RUN) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (state_q == ST_RUN && !tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        if (state_q == ST_ALARM) begin
            phase_d = phase_q;
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    assign any_btn = btn_start | btn_stop | btn_min | btn_sec;

    // The if/else order inside each state encodes stop > start > min > sec.
    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_inc_min = 1'b0;
        cnt_inc_sec = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (btn_stop) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (btn_start) begin
                    if (!time_zero) begin
                        state_d = ST_RUN;
                    end
                end else if (btn_min) begin
                    cnt_inc_min = 1'b1;
                end else if (btn_sec) begin
                    cnt_inc_sec = 1'b1;
                end
            end
            ST_RUN: begin
                if (btn_stop) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                    if (time_one) begin
                        state_d = ST_ALARM;
                    end
                end
            end
            ST_ALARM: begin
                if (any_btn) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign blank      = (state_q == ST_ALARM) && phase_q;
    assign frame_edge = vsync && !vsync_prev_q;

    always_comb begin
        bcd_d = bcd_q;
        if (frame_edge) begin
            bcd_d = {digit_code(blank, mm_tens), digit_code(blank, mm_ones),
                     digit_code(blank, ss_tens), digit_code(blank, ss_ones)};
        end
    end

    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            vsync_prev_q <= 1'b1;
            bcd_q        <= 32'h0;
            running_q    <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            vsync_prev_q <= vsync;
            bcd_q        <= bcd_d;
            running_q    <= (state_q == ST_RUN);
            alarm_q      <= (state_q == ST_ALARM);
        end
    end

    assign bcd1    = bcd_q[31:24];
    assign bcd2    = bcd_q[23:16];
    assign bcd3    = bcd_q[15:8];
    assign bcd4    = bcd_q[7:0];
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_timer_display_ctrl.sv
// tb/tb_timer_display_ctrl.sv - self-checking bench for timer_display_ctrl
module tb_timer_display_ctrl;

    logic       dclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       vsync = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic [7:0] bcd1, bcd2, bcd3, bcd4;
    logic       alarm, running;
    logic [31:0] disp;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    // button vector layout {stop, start, min, sec}
    localparam logic [3:0] B_SEC   = 4'b0001;
    localparam logic [3:0] B_MIN   = 4'b0010;
    localparam logic [3:0] B_START = 4'b0100;
    localparam logic [3:0] B_STOP  = 4'b1000;

    timer_display_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
        .dclk      (dclk),
        .clr_n     (clr_n),
        .vsync     (vsync),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .bcd4      (bcd4),
        .alarm     (alarm),
        .running   (running)
    );

    always #5 dclk = ~dclk;

    assign disp = {bcd1, bcd2, bcd3, bcd4};

    function automatic logic [31:0] exp_word(input int mm, input int ss, input bit blank);
        logic [3:0] n;
        n = blank ? 4'hF : 4'h0;
        return {n, 4'(mm / 10), n, 4'(mm % 10), n, 4'(ss / 10), n, 4'(ss % 10)};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    // Drives a one-cycle pulse; returns 1 ns after the posedge that consumed it.
    task automatic press(input logic [3:0] b);
        {btn_stop, btn_start, btn_min, btn_sec} = b;
        @(posedge dclk);
        #1;
        {btn_stop, btn_start, btn_min, btn_sec} = 4'b0000;
    endtask

    task automatic expect_disp(input int mm, input int ss, input bit blank);
        sb_q.push_back(exp_word(mm, ss, blank));
    endtask

    // Raises vsync so the next posedge is a frame boundary; the shadow copies the time of the
    // current cycle. Consumes two cycles so consecutive frames each see a fresh rising edge.
    task automatic show_frame(input string name);
        logic [31:0] exp;
        vsync = 1'b1;
        @(posedge dclk);
        #1;
        vsync = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, bcd=%h", name, disp);
        end else begin
            exp = sb_q.pop_front();
            if (disp !== exp) begin
                errors++;
                $display("FAIL %s: bcd=%h expected %h", name, disp, exp);
            end
        end
        @(posedge dclk);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (2) @(posedge dclk);
        #1;
        checks++;
        if (disp !== 32'h0) begin errors++; $display("FAIL reset_bcd: bcd=%h expected 00000000", disp); end
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: alarm=%b expected 0", alarm); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL reset_running: running=%b expected 0", running); end
        clr_n = 1'b1;
        wait_cycles(1);
        expect_disp(0, 0, 0);
        show_frame("reset_frame");
    endtask

    task automatic test_edit_wrap();
        for (int i = 0; i < 58; i++) press(B_SEC);
        expect_disp(0, 58, 0);
        show_frame("sec_58");
        for (int i = 0; i < 3; i++) press(B_SEC);
        expect_disp(0, 1, 0);
        show_frame("sec_wrap");
        for (int i = 0; i < 99; i++) press(B_MIN);
        expect_disp(99, 1, 0);
        show_frame("min_99");
        press(B_MIN);
        expect_disp(0, 1, 0);
        show_frame("min_wrap");
        press(B_STOP);
        press(B_START);
        wait_cycles(2);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL start_at_zero: running=%b expected 0", running); end
        expect_disp(0, 0, 0);
        show_frame("start_at_zero_time");
    endtask

    // k = cycles since the posedge that entered RUN; a decrement lands every 4th posedge.
    task automatic test_countdown();
        press(B_MIN);
        press(B_SEC);
        press(B_START);                      // k=0
        expect_disp(1, 1, 0);
        show_frame("cd_0101");               // k=0 -> 2
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL cd_running: running=%b expected 1", running); end
        wait_cycles(2);                      // k=4
        expect_disp(1, 0, 0);
        show_frame("cd_0100");               // k=4 -> 6
        wait_cycles(2);                      // k=8
        expect_disp(0, 59, 0);
        show_frame("cd_0059");               // k=8 -> 10
        wait_cycles(233);                    // k=243
        expect_disp(0, 1, 0);
        show_frame("cd_0001");               // k=243 -> 245, ALARM since k=244
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL cd_alarm: alarm=%b expected 1", alarm); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL cd_run_off: running=%b expected 0", running); end
        expect_disp(0, 0, 0);
        show_frame("blink_vis0");            // k=245 phase 0
        expect_disp(0, 0, 1);
        show_frame("blink_blank0");          // k=247 phase 1
        expect_disp(0, 0, 0);
        show_frame("blink_vis1");            // k=249 phase 0
        expect_disp(0, 0, 1);
        show_frame("blink_blank1");          // k=251 phase 1
        press(B_SEC);
        wait_cycles(1);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_dismiss: alarm=%b expected 0", alarm); end
        expect_disp(0, 0, 0);
        show_frame("alarm_dismiss_time");
    endtask

    task automatic test_pause();
        for (int i = 0; i < 10; i++) press(B_SEC);
        press(B_START);                      // k=0
        wait_cycles(3);                      // k=3, tick fires at the next posedge
        press(B_STOP);                       // stop and tick together
        expect_disp(0, 10, 0);
        show_frame("stop_with_tick");
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL pause_running: running=%b expected 0", running); end
        wait_cycles(8);
        expect_disp(0, 10, 0);
        show_frame("pause_hold");
        press(B_START | B_SEC);              // k=0
        expect_disp(0, 10, 0);
        show_frame("start_plus_sec");        // k=0 -> 2
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL resume_running: running=%b expected 1", running); end
        press(B_STOP);                       // lands at k=3, before the tick
        expect_disp(0, 10, 0);
        show_frame("pause_again");
        press(B_STOP);
        expect_disp(0, 0, 0);
        show_frame("pause_stop_clear");
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL idle_running: running=%b expected 0", running); end
    endtask

    task automatic test_frame_gating();
        logic [31:0] exp;
        press(B_MIN);
        wait_cycles(20);
        checks++;
        if (disp !== exp_word(0, 0, 0)) begin
            errors++; $display("FAIL gate_hold: bcd=%h expected %h", disp, exp_word(0, 0, 0));
        end
        expect_disp(1, 0, 0);
        vsync = 1'b1;
        #2;
        checks++;
        if (disp !== exp_word(0, 0, 0)) begin
            errors++; $display("FAIL gate_pre_edge: bcd=%h expected %h", disp, exp_word(0, 0, 0));
        end
        @(posedge dclk);
        #1;
        vsync = 1'b0;
        exp = sb_q.pop_front();
        checks++;
        if (disp !== exp) begin errors++; $display("FAIL gate_edge: bcd=%h expected %h", disp, exp); end
        wait_cycles(1);
        press(B_STOP);
        expect_disp(0, 0, 0);
        show_frame("gate_clear");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) press(B_SEC);
        press(B_START);
        wait_cycles(2);
        clr_n = 1'b0;
        @(posedge dclk);
        #1;
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL rst_run_running: running=%b expected 0", running); end
        checks++;
        if (disp !== 32'h0) begin errors++; $display("FAIL rst_run_bcd: bcd=%h expected 00000000", disp); end
        clr_n = 1'b1;
        wait_cycles(12);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL rst_no_resume: running=%b expected 0", running); end
        expect_disp(0, 0, 0);
        show_frame("rst_run_time");
        press(B_SEC);
        press(B_START);                      // k=0, ALARM from k=4
        wait_cycles(6);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL rst_pre_alarm: alarm=%b expected 1", alarm); end
        clr_n = 1'b0;
        @(posedge dclk);
        #1;
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm: alarm=%b expected 0", alarm); end
        clr_n = 1'b1;
        wait_cycles(3);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm_hold: alarm=%b expected 0", alarm); end
        expect_disp(0, 0, 0);
        show_frame("rst_alarm_time");
    endtask

    initial begin
        test_reset();
        test_edit_wrap();
        test_countdown();
        test_pause();
        test_frame_gating();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
